wb_commit_queue: RTL and testbench
==================================

Name: wb_commit_queue

Overview:
- Writeback commit queue between the two execution pipes and the dual-write-port register file of the superscalar MIPS datapath.
- Accepts up to two results per cycle in program order and buffers them.
- Drains up to two results per cycle onto the register file's p1/p2 write ports.
- Never presents the same destination register on both ports in one cycle, so register file write order is always defined.
- Provides a combinational forwarding lookup over all pending results.

Parameters:
- DEPTH, 8, queue entries; power of two, >= 4.
- DATA_W, 32, result data width.
- ADDR_W, 5, register index width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- in0_valid  in  1  older result valid.
- in0_reg  in  ADDR_W  older result destination.
- in0_data  in  DATA_W  older result data.
- in1_valid  in  1  younger result valid.
- in1_reg  in  ADDR_W  younger result destination.
- in1_data  in  DATA_W  younger result data.
- in_ready  out  1  queue can take two entries this cycle.
- drain_en  in  1  allow draining this cycle.
- reg_write_p1  out  1  write port 1 enable (registered).
- wr_reg_p1  out  ADDR_W  write port 1 register.
- wr_data_p1  out  DATA_W  write port 1 data.
- reg_write_p2  out  1  write port 2 enable (registered).
- wr_reg_p2  out  ADDR_W  write port 2 register.
- wr_data_p2  out  DATA_W  write port 2 data.
- fwd_reg  in  ADDR_W  forwarding lookup index.
- fwd_hit  out  1  a pending result exists for fwd_reg.
- fwd_data  out  DATA_W  youngest pending data for fwd_reg.
- count  out  log2(DEPTH)+1  occupied entries.
- empty  out  1  count == 0.

Behaviour:
- Reset (async, rst=1): head/tail/count = 0.
  - All write-port outputs = 0; fwd_hit = 0; empty = 1; in_ready = 1.
  - Reset mid-operation discards all pending entries and any in-flight write-port values immediately.
- Queue is a circular buffer of {reg, data}; pointers wrap modulo DEPTH.
- in_ready = (DEPTH - count) >= 2, computed from registered count only; same-cycle drain is not credited.
- Enqueue (posedge, in_ready=1):
  - Valid inputs with reg != 0 are written at tail, in0 before in1.
  - Tail advances by the number stored: 0, 1 or 2.
  - Inputs with reg == 0 are dropped silently.
  - Inputs present while in_ready=0 are ignored; upstream holds them.
- Drain (posedge, drain_en=1, count before edge >= 1):
  - count == 1: head goes to p1; p2 is idle.
  - count >= 2, head.reg != (head+1).reg: head goes to p1, head+1 goes to p2; pop 2.
  - count >= 2, regs equal (merge): pop 2; only the younger (head+1) is driven on p2; p1 is idle.
  - drain_en=0 or empty: both reg_write outputs are 0 the next cycle; the queue holds.
- Write-port outputs are registered and held for exactly one cycle per drain. wr_reg/wr_data hold their last values when the enable is 0.
- Latency: an entry enqueued at edge N reaches the write port after edge N+1 at the earliest. The register file commits it on the following negedge.
- Simultaneous enqueue and drain in one cycle is legal: count_next = count + stored - popped.
- Forwarding (combinational):
  - Search the registered write-port outputs plus all valid queue entries.
  - The youngest match wins. Age order, youngest first: tail-1 ... head, then p2 register, then p1 register.
  - fwd_reg == 0 gives fwd_hit = 0 and fwd_data = 0.
  - No match gives fwd_hit = 0 and fwd_data = 0.
- Ordering: non-adjacent entries with the same register drain in separate cycles, in program order.

Optional Feature:
- Macro: WBQ_STATS_EN.
- When defined, add outputs merge_cnt [15:0] and stall_cnt [15:0]. Both reset to 0 and saturate at 16'hFFFF.
  - merge_cnt increments on each merge drain.
  - stall_cnt increments on each cycle with in_ready=0 and (in0_valid|in1_valid).
- When not defined, these ports and their counters do not exist; all other behaviour is identical.

Test Plan:
1. Reset, then enqueue {in0: r3=0x11}, {in1: r4=0x22} with drain_en=1 -> next cycle reg_write_p1=1 with r3/0x11 and reg_write_p2=1 with r4/0x22; count returns to 0.
2. Enqueue r5=0xA then r5=0xB in the same cycle, drain_en=1 -> only p2 asserts with r5/0xB; p1=0; merge_cnt=1 when WBQ_STATS_EN is defined.
3. Hold drain_en=0 and enqueue pairs until count=8 -> in_ready=0 once count>=7. Further inputs are ignored; stall_cnt counts those cycles. Raise drain_en -> entries appear in enqueue order, two per cycle, with pointer wrap.
4. Enqueue r0=0xFF on in0 and r7=0x1 on in1 -> only r7 is stored (count=1); r0 never appears on either port.
5. Queue r9=0x5, then r9=0x6 one cycle later, drain_en=0, fwd_reg=9 -> fwd_hit=1, fwd_data=0x6. Then drain -> p1 r9/0x5 in one cycle, p1 r9/0x6 in the next; fwd_hit goes to 0 after the last write-port cycle.
6. Assert rst asynchronously with count=5 and p1/p2 active -> all outputs go to 0 immediately; empty=1, in_ready=1; no write is issued after rst is released.

Source files
------------

// File: rtl/wb_commit_queue.sv
// Writeback commit queue: buffers up to two in-order results per cycle from the
// execution pipes and drains up to two per cycle onto the register file's
// p1/p2 write ports. Adjacent results to the same register are merged so that
// both ports never target one register in the same cycle. A combinational
// forwarding lookup covers every pending result, including the write-port
// registers.
// Optional build macro: WBQ_STATS_EN adds saturating merge_cnt/stall_cnt outputs.
module wb_commit_queue #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in0_valid,
  input  logic [ADDR_W-1:0]        in0_reg,
  input  logic [DATA_W-1:0]        in0_data,
  input  logic                     in1_valid,
  input  logic [ADDR_W-1:0]        in1_reg,
  input  logic [DATA_W-1:0]        in1_data,
  output logic                     in_ready,
  input  logic                     drain_en,
  output logic                     reg_write_p1,
  output logic [ADDR_W-1:0]        wr_reg_p1,
  output logic [DATA_W-1:0]        wr_data_p1,
  output logic                     reg_write_p2,
  output logic [ADDR_W-1:0]        wr_reg_p2,
  output logic [DATA_W-1:0]        wr_data_p2,
  input  logic [ADDR_W-1:0]        fwd_reg,
  output logic                     fwd_hit,
  output logic [DATA_W-1:0]        fwd_data,
  output logic [$clog2(DEPTH):0]   count,
`ifdef WBQ_STATS_EN
  output logic                     empty,
  output logic [15:0]              merge_cnt,
  output logic [15:0]              stall_cnt
`else
  output logic                     empty
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Entry storage; validity is implied by head/count, so no reset is needed.
  logic [ADDR_W-1:0] reg_mem_q  [DEPTH];
  logic [DATA_W-1:0] data_mem_q [DEPTH];

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              p1_v_q, p1_v_d;
  logic [ADDR_W-1:0] p1_reg_q, p1_reg_d;
  logic [DATA_W-1:0] p1_data_q, p1_data_d;
  logic              p2_v_q, p2_v_d;
  logic [ADDR_W-1:0] p2_reg_q, p2_reg_d;
  logic [DATA_W-1:0] p2_data_q, p2_data_d;

  logic              ready_c;
  logic              st0_c, st1_c;
  logic [PTR_W-1:0]  in1_slot_c;
  logic [PTR_W-1:0]  head1_c;
  logic [CNT_W-1:0]  n_store_c, n_pop_c;
  logic              merge_c;

  logic              fwd_hit_c;
  logic [DATA_W-1:0] fwd_data_c;

  // Enqueue/drain decision and next-state for pointers and write ports.
  always_comb begin
    ready_c    = (count_q <= CNT_W'(DEPTH - 2));
    st0_c      = ready_c & in0_valid & (in0_reg != '0);
    st1_c      = ready_c & in1_valid & (in1_reg != '0);
    n_store_c  = CNT_W'(st0_c) + CNT_W'(st1_c);
    in1_slot_c = tail_q + PTR_W'(st0_c);
    head1_c    = head_q + PTR_W'(1);

    n_pop_c   = '0;
    merge_c   = 1'b0;
    p1_v_d    = 1'b0;
    p1_reg_d  = p1_reg_q;
    p1_data_d = p1_data_q;
    p2_v_d    = 1'b0;
    p2_reg_d  = p2_reg_q;
    p2_data_d = p2_data_q;

    if (drain_en && (count_q != '0)) begin
      if (count_q == CNT_W'(1)) begin
        // Lone entry goes out on p1.
        n_pop_c   = CNT_W'(1);
        p1_v_d    = 1'b1;
        p1_reg_d  = reg_mem_q[head_q];
        p1_data_d = data_mem_q[head_q];
      end else if (reg_mem_q[head_q] == reg_mem_q[head1_c]) begin
        // Same destination: the older value is dead, only the younger is written.
        n_pop_c   = CNT_W'(2);
        merge_c   = 1'b1;
        p2_v_d    = 1'b1;
        p2_reg_d  = reg_mem_q[head1_c];
        p2_data_d = data_mem_q[head1_c];
      end else begin
        n_pop_c   = CNT_W'(2);
        p1_v_d    = 1'b1;
        p1_reg_d  = reg_mem_q[head_q];
        p1_data_d = data_mem_q[head_q];
        p2_v_d    = 1'b1;
        p2_reg_d  = reg_mem_q[head1_c];
        p2_data_d = data_mem_q[head1_c];
      end
    end

    head_d  = head_q + PTR_W'(n_pop_c);
    tail_d  = tail_q + PTR_W'(n_store_c);
    count_d = count_q + n_store_c - n_pop_c;
  end

  // Write accepted results into the free slots at the tail (in0 first).
  always_ff @(posedge clk) begin
    if (st0_c) begin
      reg_mem_q[tail_q]  <= in0_reg;
      data_mem_q[tail_q] <= in0_data;
    end
    if (st1_c) begin
      reg_mem_q[in1_slot_c]  <= in1_reg;
      data_mem_q[in1_slot_c] <= in1_data;
    end
  end

  // Pointer, occupancy and write-port registers; reset flushes everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      p1_v_q    <= 1'b0;
      p1_reg_q  <= '0;
      p1_data_q <= '0;
      p2_v_q    <= 1'b0;
      p2_reg_q  <= '0;
      p2_data_q <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      p1_v_q    <= p1_v_d;
      p1_reg_q  <= p1_reg_d;
      p1_data_q <= p1_data_d;
      p2_v_q    <= p2_v_d;
      p2_reg_q  <= p2_reg_d;
      p2_data_q <= p2_data_d;
    end
  end

  // Forwarding: scan oldest to youngest so the youngest match overwrites.
  always_comb begin
    fwd_hit_c  = 1'b0;
    fwd_data_c = '0;
    if (fwd_reg != '0) begin
      if (p1_v_q && (p1_reg_q == fwd_reg)) begin
        fwd_hit_c  = 1'b1;
        fwd_data_c = p1_data_q;
      end
      if (p2_v_q && (p2_reg_q == fwd_reg)) begin
        fwd_hit_c  = 1'b1;
        fwd_data_c = p2_data_q;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if ((CNT_W'(i) < count_q) && (reg_mem_q[head_q + PTR_W'(i)] == fwd_reg)) begin
          fwd_hit_c  = 1'b1;
          fwd_data_c = data_mem_q[head_q + PTR_W'(i)];
        end
      end
    end
  end

  assign in_ready     = ready_c;
  assign reg_write_p1 = p1_v_q;
  assign wr_reg_p1    = p1_reg_q;
  assign wr_data_p1   = p1_data_q;
  assign reg_write_p2 = p2_v_q;
  assign wr_reg_p2    = p2_reg_q;
  assign wr_data_p2   = p2_data_q;
  assign fwd_hit      = fwd_hit_c;
  assign fwd_data     = fwd_data_c;
  assign count        = count_q;
  assign empty        = (count_q == '0);

`ifdef WBQ_STATS_EN
  logic [15:0] merge_cnt_q, merge_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Next values of the statistics counters.
  always_comb begin
    merge_cnt_d = merge_c ? sat_inc16(merge_cnt_q) : merge_cnt_q;
    stall_cnt_d = (!ready_c && (in0_valid || in1_valid)) ? sat_inc16(stall_cnt_q) : stall_cnt_q;
  end

  // Statistics counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      merge_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      merge_cnt_q <= merge_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign merge_cnt = merge_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_wb_commit_queue.sv
// Testbench for wb_commit_queue: a directed vector table, hand-written
// multi-cycle sequences and a randomized run, all checked against a
// queue-based reference model of the commit rules.
module tb_wb_commit_queue;

  localparam int DEPTH  = 8;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              in0_valid, in1_valid, drain_en;
  logic [ADDR_W-1:0] in0_reg, in1_reg, fwd_reg;
  logic [DATA_W-1:0] in0_data, in1_data;
  logic              in_ready, reg_write_p1, reg_write_p2, fwd_hit, empty;
  logic [ADDR_W-1:0] wr_reg_p1, wr_reg_p2;
  logic [DATA_W-1:0] wr_data_p1, wr_data_p2, fwd_data;
  logic [$clog2(DEPTH):0] count;
`ifdef WBQ_STATS_EN
  logic [15:0] merge_cnt, stall_cnt;
`endif

  always #5 clk = ~clk;

  wb_commit_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .in0_valid(in0_valid), .in0_reg(in0_reg), .in0_data(in0_data),
    .in1_valid(in1_valid), .in1_reg(in1_reg), .in1_data(in1_data),
    .in_ready(in_ready), .drain_en(drain_en),
    .reg_write_p1(reg_write_p1), .wr_reg_p1(wr_reg_p1), .wr_data_p1(wr_data_p1),
    .reg_write_p2(reg_write_p2), .wr_reg_p2(wr_reg_p2), .wr_data_p2(wr_data_p2),
    .fwd_reg(fwd_reg), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .count(count),
`ifdef WBQ_STATS_EN
    .empty(empty), .merge_cnt(merge_cnt), .stall_cnt(stall_cnt)
`else
    .empty(empty)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [ADDR_W-1:0] r;
    logic [DATA_W-1:0] d;
  } ent_t;

  ent_t              mq[$];
  logic              m_p1v, m_p2v;
  logic [ADDR_W-1:0] m_p1r, m_p2r;
  logic [DATA_W-1:0] m_p1d, m_p2d;
  int                m_merge, m_stall;

  function automatic void model_reset();
    mq.delete();
    m_p1v = 0; m_p1r = '0; m_p1d = '0;
    m_p2v = 0; m_p2r = '0; m_p2d = '0;
    m_merge = 0; m_stall = 0;
  endfunction

  // One clock edge worth of behaviour, computed from the pre-edge state and inputs.
  function automatic void model_step();
    bit   ready;
    ent_t a, b;
    ready = (DEPTH - mq.size()) >= 2;
    if (!ready && (in0_valid || in1_valid) && m_stall < 16'hFFFF) m_stall++;
    m_p1v = 0;
    m_p2v = 0;
    if (drain_en && mq.size() >= 1) begin
      if (mq.size() == 1) begin
        a = mq.pop_front();
        m_p1v = 1; m_p1r = a.r; m_p1d = a.d;
      end else begin
        a = mq.pop_front();
        b = mq.pop_front();
        if (a.r == b.r) begin
          if (m_merge < 16'hFFFF) m_merge++;
        end else begin
          m_p1v = 1; m_p1r = a.r; m_p1d = a.d;
        end
        m_p2v = 1; m_p2r = b.r; m_p2d = b.d;
      end
    end
    if (ready) begin
      if (in0_valid && in0_reg != 0) mq.push_back('{r: in0_reg, d: in0_data});
      if (in1_valid && in1_reg != 0) mq.push_back('{r: in1_reg, d: in1_data});
    end
  endfunction

  function automatic logic [DATA_W:0] model_fwd(input logic [ADDR_W-1:0] r);
    if (r == 0) return '0;
    for (int i = mq.size() - 1; i >= 0; i--)
      if (mq[i].r == r) return {1'b1, mq[i].d};
    if (m_p2v && m_p2r == r) return {1'b1, m_p2d};
    if (m_p1v && m_p1r == r) return {1'b1, m_p1d};
    return '0;
  endfunction

  task automatic compare_all(input string tag);
    logic [DATA_W:0] f;
    f = model_fwd(fwd_reg);
    chk({tag, ".reg_write_p1"}, reg_write_p1, m_p1v);
    chk({tag, ".wr_reg_p1"},    wr_reg_p1,    m_p1r);
    chk({tag, ".wr_data_p1"},   wr_data_p1,   m_p1d);
    chk({tag, ".reg_write_p2"}, reg_write_p2, m_p2v);
    chk({tag, ".wr_reg_p2"},    wr_reg_p2,    m_p2r);
    chk({tag, ".wr_data_p2"},   wr_data_p2,   m_p2d);
    chk({tag, ".count"},        count,        mq.size());
    chk({tag, ".empty"},        empty,        mq.size() == 0);
    chk({tag, ".in_ready"},     in_ready,     (DEPTH - mq.size()) >= 2);
    chk({tag, ".fwd_hit"},      fwd_hit,      f[DATA_W]);
    chk({tag, ".fwd_data"},     fwd_data,     f[DATA_W-1:0]);
`ifdef WBQ_STATS_EN
    chk({tag, ".merge_cnt"},    merge_cnt,    m_merge);
    chk({tag, ".stall_cnt"},    stall_cnt,    m_stall);
`endif
  endtask

  task automatic set_in(input logic v0, input logic [ADDR_W-1:0] r0, input logic [DATA_W-1:0] d0,
                        input logic v1, input logic [ADDR_W-1:0] r1, input logic [DATA_W-1:0] d1,
                        input logic den);
    in0_valid = v0; in0_reg = r0; in0_data = d0;
    in1_valid = v1; in1_reg = r1; in1_data = d1;
    drain_en  = den;
  endtask

  task automatic cycle(input string tag);
    model_step();
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic v0; logic [ADDR_W-1:0] r0; logic [DATA_W-1:0] d0;
    logic v1; logic [ADDR_W-1:0] r1; logic [DATA_W-1:0] d1;
    logic den;
    logic ep1; logic [ADDR_W-1:0] er1; logic [DATA_W-1:0] ed1;
    logic ep2; logic [ADDR_W-1:0] er2; logic [DATA_W-1:0] ed2;
    int   ecnt;
  } vec_t;

  vec_t tbl[8];

  initial begin
    // pair enqueue, then both ports next cycle
    tbl[0] = '{1, 5'd3, 32'h11, 1, 5'd4, 32'h22, 1,  0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  2};
    tbl[1] = '{0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  1,  1, 5'd3, 32'h11, 1, 5'd4, 32'h22, 0};
    tbl[2] = '{0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  1,  0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  0};
    // same register pair merges onto p2 only
    tbl[3] = '{1, 5'd5, 32'hA,  1, 5'd5, 32'hB,  1,  0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  2};
    tbl[4] = '{0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  1,  0, 5'd0, 32'h0,  1, 5'd5, 32'hB,  0};
    // r0 is dropped, r7 stored alone and drained on p1
    tbl[5] = '{1, 5'd0, 32'hFF, 1, 5'd7, 32'h1,  0,  0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  1};
    tbl[6] = '{0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  1,  1, 5'd7, 32'h1,  0, 5'd0, 32'h0,  0};
    tbl[7] = '{0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  0,  0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  0};

    rst = 1'b1;
    fwd_reg = '0;
    set_in(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      set_in(tbl[i].v0, tbl[i].r0, tbl[i].d0, tbl[i].v1, tbl[i].r1, tbl[i].d1, tbl[i].den);
      cycle($sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d.p1_en", i), reg_write_p1, tbl[i].ep1);
      if (tbl[i].ep1) begin
        chk($sformatf("tbl%0d.p1_reg", i),  wr_reg_p1,  tbl[i].er1);
        chk($sformatf("tbl%0d.p1_data", i), wr_data_p1, tbl[i].ed1);
      end
      chk($sformatf("tbl%0d.p2_en", i), reg_write_p2, tbl[i].ep2);
      if (tbl[i].ep2) begin
        chk($sformatf("tbl%0d.p2_reg", i),  wr_reg_p2,  tbl[i].er2);
        chk($sformatf("tbl%0d.p2_data", i), wr_data_p2, tbl[i].ed2);
      end
      chk($sformatf("tbl%0d.count", i), count, tbl[i].ecnt);
`ifdef WBQ_STATS_EN
      if (i == 4) chk("tbl4.merge_cnt", merge_cnt, 1);
`endif
    end

    // ---- fill to full, stall, then drain across the pointer wrap ----
    for (int k = 0; k < 4; k++) begin
      set_in(1, 5'(2*k+1), 32'(256+2*k+1), 1, 5'(2*k+2), 32'(256+2*k+2), 0);
      cycle($sformatf("fill%0d", k));
    end
    chk("full.count", count, 8);
    chk("full.in_ready", in_ready, 0);
    set_in(1, 5'd20, 32'hDEAD, 1, 5'd21, 32'hBEEF, 0);
    cycle("stall0");
    cycle("stall1");
    chk("stall.count", count, 8);
`ifdef WBQ_STATS_EN
    chk("stall.stall_cnt", stall_cnt, 2);
`endif
    set_in(0, 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 4; k++) begin
      cycle($sformatf("drain%0d", k));
      chk($sformatf("drain%0d.p1_reg", k),  wr_reg_p1,  5'(2*k+1));
      chk($sformatf("drain%0d.p1_data", k), wr_data_p1, 32'(256+2*k+1));
      chk($sformatf("drain%0d.p2_reg", k),  wr_reg_p2,  5'(2*k+2));
      chk($sformatf("drain%0d.p2_en", k),   reg_write_p2, 1);
    end
    chk("drain.empty", empty, 1);

    // ---- forwarding picks the youngest; non-adjacent duplicates stay in order ----
    set_in(1, 5'd9, 32'h5, 0, 0, 0, 0);
    cycle("fw_a");
    set_in(1, 5'd10, 32'h77, 0, 0, 0, 0);
    cycle("fw_b");
    set_in(1, 5'd9, 32'h6, 0, 0, 0, 0);
    cycle("fw_c");
    set_in(0, 0, 0, 0, 0, 0, 0);
    fwd_reg = 5'd9;
    #1;
    chk("fw.hit9", fwd_hit, 1);
    chk("fw.data9", fwd_data, 32'h6);
    fwd_reg = 5'd10;
    #1;
    chk("fw.data10", fwd_data, 32'h77);
    fwd_reg = 5'd0;
    #1;
    chk("fw.hit0", fwd_hit, 0);
    fwd_reg = 5'd9;
    drain_en = 1'b1;
    cycle("fw_d0");
    chk("fw_d0.p1", {reg_write_p1, wr_reg_p1, wr_data_p1}, {1'b1, 5'd9, 32'h5});
    chk("fw_d0.p2", {reg_write_p2, wr_reg_p2, wr_data_p2}, {1'b1, 5'd10, 32'h77});
    chk("fw_d0.fwd", {fwd_hit, fwd_data}, {1'b1, 32'h6});
    cycle("fw_d1");
    chk("fw_d1.p1", {reg_write_p1, wr_reg_p1, wr_data_p1}, {1'b1, 5'd9, 32'h6});
    chk("fw_d1.p2en", reg_write_p2, 0);
    chk("fw_d1.fwd", {fwd_hit, fwd_data}, {1'b1, 32'h6});
    cycle("fw_d2");
    chk("fw_d2.fwd_hit", fwd_hit, 0);

    // ---- asynchronous reset with entries pending and ports active ----
    drain_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_in(1, 5'(11+2*k), 32'(k+100), 1, 5'(12+2*k), 32'(k+200), 0);
      cycle($sformatf("rs_fill%0d", k));
    end
    set_in(1, 5'd17, 32'h1717, 0, 0, 0, 1);
    cycle("rs_busy");
    chk("rs_busy.count", count, 5);
    chk("rs_busy.ports", {reg_write_p1, reg_write_p2}, 2'b11);
    set_in(0, 0, 0, 0, 0, 0, 0);
    fwd_reg = 5'd13;
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    compare_all("async_rst");
    chk("async_rst.ports", {reg_write_p1, reg_write_p2, wr_reg_p1, wr_reg_p2}, '0);
    chk("async_rst.empty_ready", {empty, in_ready, fwd_hit}, 3'b110);
    @(negedge clk);
    rst = 1'b0;
    drain_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle($sformatf("post_rst%0d", k));
      chk($sformatf("post_rst%0d.nowrite", k), {reg_write_p1, reg_write_p2}, 2'b00);
    end

    // ---- randomized traffic against the model ----
    for (int n = 0; n < 400; n++) begin
      set_in(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
             1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
             1'($urandom_range(0, 9) < 5));
      fwd_reg = 5'($urandom_range(0, 7));
      if (n == 250) begin
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        compare_all("rnd_rst");
        @(negedge clk);
        rst = 1'b0;
      end
      cycle($sformatf("rnd%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
